// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter: access-type codes,
// master ids, arbiter FSM encoding and the read-return tag.
package bus_pkg;

  localparam logic [2:0] ACC_IDLE   = 3'b000;
  localparam logic [2:0] ACC_BYTE   = 3'b001;
  localparam logic [2:0] ACC_HALF   = 3'b010;
  localparam logic [2:0] ACC_WORD   = 3'b011;
  localparam logic [2:0] ACC_BYTE_U = 3'b100;
  localparam logic [2:0] ACC_HALF_U = 3'b101;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift pipeline carrying {valid, id} for each issued transfer,
// so read data can be steered back to the master that issued the read.
module rd_tag_pipe
  import bus_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [DEPTH];

  // Shift one stage per cycle; reset drops every read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master arbiter in front of bus_controller. Master 0 has fixed
// priority; master 1 is protected against starvation; either master may
// lock the bus for a bounded number of consecutive transfers.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_IDLE  | no lock held, normal priority arbitration
//   ST_LOCK0 | master 0 owns the bus, master 1 held off
//   ST_LOCK1 | master 1 owns the bus, master 0 held off
module sys_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [2:0]        m0_ctrl,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [2:0]        m1_ctrl,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [2:0]        s_ctrl,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_we,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              lock_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     starve_cnt;
  logic [LW-1:0]     lock_cnt, lock_cnt_d, lock_next;
  logic              pri_vld_q, pri_vld_d;
  logic              pri_id_q, pri_id_d;
  logic              lock_err_d;
  logic              starve_sat, favour1, gnt_lock;
  rd_tag_t           tag_in, tag_out;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign starve_sat = (starve_cnt == SW'(STARVE_MAX));

  // Grant decision: owner-only while locked, otherwise m0 first unless a
  // post-break priority or m1 starvation says otherwise. Nothing during reset.
  always_comb begin
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    favour1 = pri_vld_q ? (pri_id_q == M1) : (m1_req && starve_sat);
    case (state_q)
      ST_LOCK0: m0_gnt = m0_req;
      ST_LOCK1: m1_gnt = m1_req;
      default: begin
        if (favour1) begin
          m1_gnt = m1_req;
          m0_gnt = m0_req && !m1_req;
        end else begin
          m0_gnt = m0_req;
          m1_gnt = m1_req && !m0_req;
        end
      end
    endcase
    if (!rst_n) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end
  end

  // Lock tracking: any cycle without a locked grant returns to IDLE; a
  // locked grant that reaches LOCK_MAX breaks the lock and hands priority over.
  always_comb begin
    state_d    = ST_IDLE;
    lock_cnt_d = '0;
    pri_vld_d  = 1'b0;
    pri_id_d   = pri_id_q;
    lock_err_d = 1'b0;
    gnt_lock   = (m0_gnt && m0_lock) || (m1_gnt && m1_lock);
    lock_next  = (state_q == ST_IDLE) ? LW'(1) : lock_cnt + LW'(1);
    if (gnt_lock) begin
      if (lock_next >= LW'(LOCK_MAX)) begin
        lock_err_d = 1'b1;
        pri_vld_d  = 1'b1;
        pri_id_d   = m1_gnt ? M0 : M1;
      end else begin
        state_d    = m1_gnt ? ST_LOCK1 : ST_LOCK0;
        lock_cnt_d = lock_next;
      end
    end
  end

  // FSM, lock counter, break priority and lock_err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lock_cnt  <= '0;
      pri_vld_q <= 1'b0;
      pri_id_q  <= M0;
      lock_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_cnt  <= lock_cnt_d;
      pri_vld_q <= pri_vld_d;
      pri_id_q  <= pri_id_d;
      lock_err  <= lock_err_d;
    end
  end

  // Count consecutive refused m1 requests, saturating at STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!m1_req || m1_gnt) begin
      starve_cnt <= '0;
    end else if (!starve_sat) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Slave port follows the granted master; idle access when nobody is granted.
  always_comb begin
    s_addr  = m0_addr;
    s_wdata = m0_wdata;
    s_ctrl  = ACC_IDLE;
    s_we    = 1'b0;
    if (m1_gnt) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_ctrl  = m1_ctrl;
      s_we    = m1_we;
    end else if (m0_gnt) begin
      s_ctrl  = m0_ctrl;
      s_we    = m0_we;
    end
  end

  assign tag_in.valid = (m0_gnt || m1_gnt) && !s_we;
  assign tag_in.id    = m1_gnt ? M1 : M0;

  rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign m0_rvalid = tag_out.valid && (tag_out.id == M0);
  assign m1_rvalid = tag_out.valid && (tag_out.id == M1);
  assign m0_rdata  = m0_rvalid ? s_rdata : rdata0_q;
  assign m1_rdata  = m1_rvalid ? s_rdata : rdata1_q;

  // Keep each master's last returned word so rdata holds between returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (m0_rvalid) rdata0_q <= s_rdata;
      if (m1_rvalid) rdata1_q <= s_rdata;
    end
  end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a behavioural model plus a read scoreboard.
module tb_sys_bus_arbiter;
  import bus_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;
  localparam int LOCK_MAX   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [2:0]  m0_ctrl = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [2:0]  m1_ctrl = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_we, lock_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [2:0]  s_ctrl;
  logic [31:0] s_rdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  sys_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
    .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_ctrl(m0_ctrl), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_ctrl(m1_ctrl), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_ctrl(s_ctrl), .s_wdata(s_wdata), .s_we(s_we),
    .s_rdata(s_rdata), .lock_err(lock_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One-cycle-latency slave standing in for data_mem / GPIO.
  logic [31:0] slave_mem [logic [31:0]];
  always @(posedge clk) begin
    if (s_ctrl != ACC_IDLE) begin
      if (s_we) slave_mem[s_addr] = s_wdata;
      else s_rdata <= slave_mem.exists(s_addr) ? slave_mem[s_addr] : 32'h0;
    end
  end

  // Reference memory updated only from the bench's own expected transfers.
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  int owner = -1;
  int locked_run = 0;
  int refused_run = 0;
  int prio_next = -1;
  bit exp_lock_err = 1'b0;
  bit last_g0 = 1'b0, last_g1 = 1'b0;

  // Reference model: decides the expected winner from the arbitration rules,
  // checks grants and slave-side signals, and queues expected read returns.
  always @(negedge clk) begin : ref_model
    int          win, pref;
    logic [31:0] a, d;
    logic [2:0]  c;
    logic        w, lk;
    rd_exp_t     e;
    if (!rst_n) begin
      chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
      chk("rst_s_ctrl", s_ctrl, ACC_IDLE);
      chk("rst_s_we", s_we, 0);
      chk("rst_lock_err", lock_err, 0);
      owner = -1; locked_run = 0; refused_run = 0; prio_next = -1;
      exp_lock_err = 1'b0; last_g0 = 1'b0; last_g1 = 1'b0;
      exp_q.delete();
    end else begin
      chk("lock_err", lock_err, exp_lock_err);
      if (owner == 0) win = m0_req ? 0 : -1;
      else if (owner == 1) win = m1_req ? 1 : -1;
      else begin
        pref = (prio_next >= 0) ? prio_next : ((m1_req && refused_run >= STARVE_MAX) ? 1 : 0);
        if (pref == 0) win = m0_req ? 0 : (m1_req ? 1 : -1);
        else win = m1_req ? 1 : (m0_req ? 0 : -1);
      end
      chk("m0_gnt", m0_gnt, (win == 0));
      chk("m1_gnt", m1_gnt, (win == 1));
      lk = 1'b0;
      if (win >= 0) begin
        if (win == 1) begin a = m1_addr; c = m1_ctrl; w = m1_we; d = m1_wdata; lk = m1_lock; end
        else begin a = m0_addr; c = m0_ctrl; w = m0_we; d = m0_wdata; lk = m0_lock; end
        chk("s_addr", s_addr, a);
        chk("s_ctrl", s_ctrl, c);
        chk("s_we", s_we, w);
        chk("s_wdata", s_wdata, d);
        if (w) ref_mem[a] = d;
        else begin
          e.id = win; e.data = ref_rd(a); e.due = cyc + RD_LAT;
          exp_q.push_back(e);
        end
      end else begin
        chk("idle_s_ctrl", s_ctrl, ACC_IDLE);
        chk("idle_s_we", s_we, 0);
      end
      exp_lock_err = 1'b0;
      prio_next = -1;
      if (win >= 0 && lk) begin
        locked_run = (owner < 0) ? 1 : locked_run + 1;
        owner = win;
        if (locked_run >= LOCK_MAX) begin
          owner = -1; locked_run = 0; exp_lock_err = 1'b1; prio_next = 1 - win;
        end
      end else begin
        owner = -1; locked_run = 0;
      end
      refused_run = (m1_req && win != 1) ? refused_run + 1 : 0;
      last_g0 = (win == 0);
      last_g1 = (win == 1);
    end
  end

  logic [31:0] last_rd0 = '0, last_rd1 = '0;

  // Read monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge clk) begin : rd_monitor
    rd_exp_t e;
    if (!rst_n) begin
      chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
      last_rd0 = '0;
      last_rd1 = '0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("rd_missing_due", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (m0_rvalid || m1_rvalid) begin
        if (exp_q.size() == 0) chk("rd_unexpected", {m1_rvalid, m0_rvalid}, 0);
        else begin
          e = exp_q.pop_front();
          chk("rd_both_valid", (m0_rvalid && m1_rvalid), 0);
          chk("rd_master", m1_rvalid ? 1 : 0, e.id);
          chk("rd_cycle", cyc, e.due);
          chk("rd_data", m1_rvalid ? m1_rdata : m0_rdata, e.data);
          if (m1_rvalid) last_rd1 = e.data;
          else last_rd0 = e.data;
        end
      end
      if (!m0_rvalid) chk("m0_rdata_hold", m0_rdata, last_rd0);
      if (!m1_rvalid) chk("m1_rdata_hold", m1_rdata, last_rd1);
    end
  end

  logic [31:0] addr_tbl [5] = '{32'h10, 32'h14, 32'h20, 32'h24, 32'h1000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input bit req, input bit we, input bit lk, input logic [31:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d; m0_ctrl = ACC_WORD;
  endtask

  task automatic set_m1(input bit req, input bit we, input bit lk, input logic [31:0] a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d; m1_ctrl = ACC_WORD;
  endtask

  task automatic rand_txn(input int k);
    logic r, w, l;
    logic [2:0]  c;
    logic [31:0] a, d;
    r = ($urandom_range(0, 3) != 0);
    w = ($urandom_range(0, 1) == 1);
    l = ($urandom_range(0, 3) == 0);
    a = addr_tbl[$urandom_range(0, 4)];
    c = 3'($urandom_range(1, 7));
    d = $urandom();
    if (k == 0) begin
      m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_ctrl = c; m0_wdata = d;
    end else begin
      m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_ctrl = c; m1_wdata = d;
    end
  endtask

  initial begin
    ref_mem[32'h10] = 32'hAAAA_5555;  slave_mem[32'h10] = 32'hAAAA_5555;
    ref_mem[32'h14] = 32'h1234_5678;  slave_mem[32'h14] = 32'h1234_5678;
    ref_mem[32'h20] = 32'hC0DE_0020;  slave_mem[32'h20] = 32'hC0DE_0020;
    ref_mem[32'h24] = 32'h0BAD_F00D;  slave_mem[32'h24] = 32'h0BAD_F00D;

    // Reset held with both masters requesting.
    set_m0(1, 0, 0, 32'h10, 0);
    set_m1(1, 0, 0, 32'h20, 0);
    repeat (3) @(negedge clk);
    chk("reset_no_gnt", {m1_gnt, m0_gnt}, 0);
    chk("reset_s_ctrl", s_ctrl, ACC_IDLE);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_m0_gnt", m0_gnt, 1);
    chk("release_m1_gnt", m1_gnt, 0);

    // Continuous reads from both: m1 forced through on cycle STARVE_MAX+1.
    for (int i = 2; i <= STARVE_MAX + 1; i++) begin
      tick();
      @(negedge clk);
      chk("starve_m1_gnt", m1_gnt, (i == STARVE_MAX + 1));
    end
    tick();
    @(negedge clk);
    chk("starve_m0_back", m0_gnt, 1);
    chk("starve_m1_rvalid", m1_rvalid, 1);
    chk("starve_m1_rdata", m1_rdata, 32'hC0DE_0020);
    chk("starve_m0_rvalid", m0_rvalid, 0);
    tick();
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    tick();
    tick();

    // Alternating reads return to the right master.
    set_m0(1, 0, 0, 32'h10, 0);
    @(negedge clk);
    chk("alt_m0_gnt", m0_gnt, 1);
    tick();
    set_m0(0, 0, 0, 0, 0);
    set_m1(1, 0, 0, 32'h14, 0);
    @(negedge clk);
    chk("alt_m0_rvalid", m0_rvalid, 1);
    chk("alt_m0_rdata", m0_rdata, 32'hAAAA_5555);
    chk("alt_m1_gnt", m1_gnt, 1);
    tick();
    set_m1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alt_m1_rvalid", m1_rvalid, 1);
    chk("alt_m1_rdata", m1_rdata, 32'h1234_5678);
    chk("alt_m0_rdata_hold", m0_rdata, 32'hAAAA_5555);

    // m1 locks the bus for GPIO writes; m0 held off until the unlocked write.
    tick();
    set_m1(1, 1, 1, 32'h1000, 32'h1);
    @(negedge clk);
    chk("lock_entry_m1_gnt", m1_gnt, 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      set_m0(1, 0, 0, 32'h10, 0);
      set_m1(1, 1, (i != 4), 32'h1000, 32'(i));
      @(negedge clk);
      chk("lock_m0_held_off", m0_gnt, 0);
      chk("lock_m1_gnt", m1_gnt, 1);
    end
    tick();
    set_m1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("unlock_m0_gnt", m0_gnt, 1);
    tick();
    set_m0(0, 0, 0, 0, 0);
    tick();

    // m1 never releases: lock broken after LOCK_MAX grants.
    set_m1(1, 1, 1, 32'h1000, 32'h100);
    @(negedge clk);
    chk("lockbrk_entry", m1_gnt, 1);
    tick();
    set_m0(1, 0, 0, 32'h14, 0);
    for (int i = 2; i <= LOCK_MAX; i++) begin
      @(negedge clk);
      chk("lockbrk_m1_gnt", m1_gnt, 1);
      chk("lockbrk_no_err", lock_err, 0);
      tick();
    end
    @(negedge clk);
    chk("lockbrk_err", lock_err, 1);
    chk("lockbrk_m0_gnt", m0_gnt, 1);
    chk("lockbrk_m1_off", m1_gnt, 0);
    tick();
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset while a read is in flight: its data must never be returned.
    set_m0(1, 0, 0, 32'h10, 0);
    @(negedge clk);
    chk("rstmid_m0_gnt", m0_gnt, 1);
    tick();
    set_m0(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_no_rvalid", m0_rvalid, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_quiet", m0_rvalid, 0);
      tick();
    end
    set_m0(1, 0, 0, 32'h14, 0);
    @(negedge clk);
    chk("rstmid_resume_gnt", m0_gnt, 1);
    tick();
    set_m0(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstmid_resume_rvalid", m0_rvalid, 1);
    chk("rstmid_resume_rdata", m0_rdata, 32'h1234_5678);

    // Random traffic: each master keeps its request until granted.
    for (int n = 0; n < 600; n++) begin
      tick();
      if (!m0_req || last_g0) rand_txn(0);
      if (!m1_req || last_g1) rand_txn(1);
    end
    tick();
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    repeat (RD_LAT + 3) tick();
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
Two-master arbiter in front of bus_controller. It shares the single system bus, and through it data_mem and GPIO, between the riscv core (master 0) and a second master such as the program loader or a DMA engine (master 1). It issues at most one transfer per cycle, tags each read, and returns read data to the issuing master after the fixed slave read latency. Master 0 has fixed priority, with starvation protection and bus locking.

Parameters:
ADDR_W, 32, address width of both masters and the slave port
DATA_W, 32, data width
RD_LAT, 1, cycles from read issue to valid s_rdata (data_mem is one-cycle BRAM); legal range 1..4
STARVE_MAX, 8, consecutive cycles master 1 may be refused by master-0 priority before it is forced a grant
LOCK_MAX, 16, maximum consecutive locked grants before the lock is forcibly broken

Ports:
clk  in  1  system clock (clk_50m domain)
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 transfer request
m0_we  in  1  1 = write, 0 = read
m0_lock  in  1  keep ownership after this transfer
m0_addr  in  ADDR_W  address
m0_ctrl  in  3  access type, passed through unchanged
m0_wdata  in  DATA_W  write data
m0_gnt  out  1  transfer accepted this cycle (combinational)
m0_rvalid  out  1  read data valid
m0_rdata  out  DATA_W  read data
m1_req, m1_we, m1_lock, m1_addr, m1_ctrl, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for master 1
s_addr  out  ADDR_W  address to bus_controller
s_ctrl  out  3  access type; 3'b000 (ACC_IDLE) when no grant
s_wdata  out  DATA_W  write data
s_we  out  1  write strobe
s_rdata  in  DATA_W  read data from bus_controller
lock_err  out  1  one-cycle pulse when a lock is forcibly broken

Behaviour:
- Reset: all gnt, rvalid and lock_err = 0; rdata = 0; s_ctrl = ACC_IDLE; s_we = 0; state = IDLE; starve_cnt = 0; lock_cnt = 0; read tag pipeline cleared.
- Reset asserted mid-transfer: in-flight reads are discarded and no rvalid is produced.
- Grant path is combinational, with zero added latency. The s_* outputs mux the granted master's signals in the same cycle. No grant means s_ctrl = ACC_IDLE and s_we = 0.
- Exactly one gnt may be high per cycle. gnt is high only when the matching req is high.
- FSM states:
  - IDLE: no lock held.
  - LOCK0: master 0 owns the bus.
  - LOCK1: master 1 owns the bus.
- Entry to LOCKx: a granted transfer with mx_lock = 1.
- Exit from LOCKx to IDLE:
  - a granted owner transfer with lock = 0, or
  - owner req low for one cycle, or
  - lock_cnt reaches LOCK_MAX; this also pulses lock_err and gives the other master priority for one cycle.
- In LOCKx only master x can be granted. The other master's req is held off.
- Arbitration in IDLE:
  - Master 0 wins by default.
  - If m1_req has been refused for STARVE_MAX consecutive cycles, master 1 wins this cycle and starve_cnt is cleared.
- starve_cnt counts cycles with m1_req = 1 and m1_gnt = 0. It clears on m1_gnt or when m1_req drops, and saturates at STARVE_MAX.
- lock_cnt counts granted cycles while in LOCKx and clears on leaving LOCKx.
- Read return:
  - Each granted read pushes (valid = 1, id) into an RD_LAT-deep shift pipeline; a write or an idle cycle pushes valid = 0.
  - At the pipeline output, mid_rvalid pulses for one cycle and mid_rdata is registered to s_rdata from that cycle.
  - The other master's rdata holds its last value.
- Back-to-back reads by alternating masters must each be returned to the correct master.
- A write and a read return in the same cycle are independent.
- A master must hold req, addr, we, ctrl and wdata stable until gnt. The arbiter does not check this.

Decomposition:
- Shared package (bus_pkg): ACC_IDLE = 3'b000 and the other access-type codes, master id constants M0 = 1'b0 and M1 = 1'b1, FSM state encodings.
- One sub-module, rd_tag_pipe: an RD_LAT-deep shift register of {valid, id} with asynchronous reset.
- Arbitration, FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst_n = 0 with both req = 1 -> no gnt, s_ctrl = 000; release -> m0_gnt on the first cycle, m1_gnt = 0.
- Priority and starvation: both masters read continuously from 0x0000_0010 (m0) and 0x0000_0020 (m1), STARVE_MAX = 8 -> m1_gnt in cycle 9, then m0 again. m1_rvalid appears one cycle after its grant with data_mem[0x20] and m0_rvalid = 0 in that cycle.
- Alternating reads: m0 reads 0x10 (0xAAAA_5555) and m1 reads 0x14 (0x1234_5678) in consecutive cycles -> m0_rvalid carries 0xAAAA_5555, then m1_rvalid carries 0x1234_5678.
- Lock: m1 issues 3 locked writes to GPIO 0x0000_1000 while m0_req = 1 -> m0_gnt stays 0 for all 3. m1's 4th write with lock = 0 releases the bus -> m0_gnt high the next cycle.
- Lock break: m1 holds lock = 1 with continuous requests, LOCK_MAX = 16 -> lock_err pulses after 16 grants and m0_gnt is high on the following cycle.
- Reset mid-read: m0 read granted, rst_n pulsed low before the data returns -> m0_rvalid never asserts; normal operation resumes after release.
